// File: rtl/rsa_bridge_pkg.sv
// rsa_bridge_pkg: shared types and constants for the UART-to-RSA stream bridge.
// Session/bus state encodings, escape codes and the block-size helper.
package rsa_bridge_pkg;

    typedef enum logic [1:0] {
        P_KEY,
        P_DATA,
        P_ESC,
        P_END
    } session_state_e;

    typedef enum logic [1:0] {
        B_POLL,
        B_RX,
        B_TX
    } bus_state_e;

    // Block values with special meaning; only the low byte can be non-zero.
    localparam logic [7:0] ESC_CODE     = 8'h00;
    localparam logic [7:0] ESC_END_CODE = 8'h01;

    // Bytes per block for a requested width; out-of-range widths fall back
    // to the full register width.
    function automatic int unsigned chunk_bytes(
        input int unsigned bits,
        input int unsigned max_w
    );
        int unsigned w;
        w = (bits == 0 || bits > max_w) ? max_w : bits;
        return w / 8;
    endfunction

endpackage

// File: rtl/rsa_byte_fifo.sv
// rsa_byte_fifo: synchronous FIFO with full/empty flags.
// Ports: push/wdata, pop/rdata (head, valid while !empty), full, empty.
module rsa_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             avm_clk,
    input  logic             avm_rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wp;
    logic [AW:0]      rp;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) &&
                     (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle makes room, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rp[AW-1:0]];

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) begin
                mem[wp[AW-1:0]] <= wdata;
                wp <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rsa_stream_bridge.sv
// rsa_stream_bridge: Avalon-MM master on a UART register file feeding an
// external RSA exponentiation core, with RX/compute/TX overlap.
// Ports: avm_* bus master, i_rsa_bits width select, o_core_* operands and
// start, i_core_result/i_core_done, o_ready (key phase), o_busy.
module rsa_stream_bridge
    import rsa_bridge_pkg::*;
#(
    parameter int RSA_W       = 1024,
    parameter int TXQ_DEPTH   = 16,
    parameter int RX_ADDR     = 0,
    parameter int TX_ADDR     = 4,
    parameter int STATUS_ADDR = 8,
    parameter int RX_OK_BIT   = 7,
    parameter int TX_OK_BIT   = 6
) (
    input  logic                     avm_clk,
    input  logic                     avm_rst_n,
    input  logic [$clog2(RSA_W):0]   i_rsa_bits,
    output logic [4:0]               avm_address,
    output logic                     avm_read,
    output logic                     avm_write,
    input  logic [31:0]              avm_readdata,
    output logic [31:0]              avm_writedata,
    input  logic                     avm_waitrequest,
    output logic                     o_core_start,
    output logic [RSA_W-1:0]         o_core_a,
    output logic [RSA_W-1:0]         o_core_e,
    output logic [RSA_W-1:0]         o_core_n,
    input  logic [RSA_W-1:0]         i_core_result,
    input  logic                     i_core_done,
    output logic                     o_ready,
    output logic                     o_busy
);

    // Counter wide enough for a full key (2 * RSA_W/8 bytes).
    localparam int CHW = $clog2(RSA_W / 4) + 1;
    localparam int LW  = $clog2(RSA_W);

    session_state_e   r_sess;
    bus_state_e       r_bus;

    logic [CHW-1:0]   r_chunk;
    logic [CHW-1:0]   r_cnt;
    logic [CHW-1:0]   r_ucnt;
    logic [RSA_W-1:0] r_n;
    logic [RSA_W-1:0] r_e;
    logic [RSA_W-1:0] r_acc;
    logic [RSA_W-1:0] r_op;
    logic [RSA_W-1:0] r_res;
    logic             r_nz;
    logic             r_pend;
    logic             r_opbusy;
    logic             r_run;
    logic             r_unload;
    logic             r_start;
    logic             rx_stb;
    logic [7:0]       rx_byte;

    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_head;
    logic [7:0]       push_byte;
    logic [CHW-1:0]   res_idx;
    logic [LW-1:0]    res_base;

    logic             nz_prev;
    logic             blk_last;
    logic             blk_zero;
    logic             blk_one;
    logic [CHW-1:0]   key_last;
    logic             rx_stall;
    logic             unused_rd;

    assign unused_rd = ^avm_readdata;

    // Shift a byte into the low end; clr starts a fresh value so stale
    // bits above the active width never survive.
    function automatic logic [RSA_W-1:0] shift_in(
        input logic [RSA_W-1:0] cur,
        input logic             clr,
        input logic [7:0]       b
    );
        logic [RSA_W-1:0] base;
        base = clr ? '0 : cur;
        return {base[RSA_W-9:0], b};
    endfunction

    always_comb begin
        nz_prev  = (r_cnt != '0) && r_nz;
        blk_last = (r_cnt == r_chunk - CHW'(1));
        blk_zero = !nz_prev && (rx_byte == ESC_CODE);
        blk_one  = !nz_prev && (rx_byte == ESC_END_CODE);
        key_last = {r_chunk[CHW-2:0], 1'b0} - CHW'(1);
    end

    // Result bytes go out MSB first, skipping the top byte of the block.
    assign res_idx   = r_chunk - CHW'(2) - r_ucnt;
    assign res_base  = LW'({res_idx, 3'b000});
    assign push_byte = r_res[res_base +: 8];
    assign fifo_pop  = (r_bus == B_TX) && !avm_waitrequest;
    assign fifo_push = r_unload && (!fifo_full || fifo_pop);

    // rx_stb is included so a poll finishing alongside the final byte of a
    // block cannot launch one read too many.
    assign rx_stall = r_pend || rx_stb || (r_sess == P_END);

    assign o_core_start = r_start;
    assign o_core_a     = r_op;
    assign o_core_e     = r_e;
    assign o_core_n     = r_n;
    assign o_ready      = (r_sess == P_KEY);
    assign o_busy       = r_run || r_unload || !fifo_empty;

    rsa_byte_fifo #(
        .DEPTH (TXQ_DEPTH),
        .WIDTH (8)
    ) u_txq (
        .avm_clk   (avm_clk),
        .avm_rst_n (avm_rst_n),
        .push      (fifo_push),
        .wdata     (push_byte),
        .pop       (fifo_pop),
        .rdata     (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            r_sess   <= P_KEY;
            r_chunk  <= CHW'(RSA_W / 8);
            r_cnt    <= '0;
            r_ucnt   <= '0;
            r_n      <= '0;
            r_e      <= '0;
            r_acc    <= '0;
            r_op     <= '0;
            r_res    <= '0;
            r_nz     <= 1'b0;
            r_pend   <= 1'b0;
            r_opbusy <= 1'b0;
            r_run    <= 1'b0;
            r_unload <= 1'b0;
            r_start  <= 1'b0;
        end else begin
            r_start <= 1'b0;

            if (r_sess == P_KEY && r_cnt == '0) begin
                r_chunk <= CHW'(chunk_bytes(32'(i_rsa_bits), RSA_W));
            end

            if (r_pend && !r_opbusy) begin
                r_op     <= r_acc;
                r_pend   <= 1'b0;
                r_opbusy <= 1'b1;
                r_run    <= 1'b1;
                r_start  <= 1'b1;
            end

            // r_run gates done so a stale pulse after reset is dropped.
            if (i_core_done && r_run) begin
                r_run    <= 1'b0;
                r_res    <= i_core_result;
                r_unload <= 1'b1;
                r_ucnt   <= '0;
            end

            if (fifo_push) begin
                if (r_ucnt == r_chunk - CHW'(2)) begin
                    r_unload <= 1'b0;
                    r_opbusy <= 1'b0;
                end else begin
                    r_ucnt <= r_ucnt + 1'b1;
                end
            end

            if (rx_stb) begin
                unique case (r_sess)
                    P_KEY: begin
                        if (r_cnt < r_chunk) begin
                            r_n <= shift_in(r_n, r_cnt == '0, rx_byte);
                        end else begin
                            r_e <= shift_in(r_e, r_cnt == r_chunk,
                                            rx_byte);
                        end
                        if (r_cnt == key_last) begin
                            r_cnt  <= '0;
                            r_sess <= P_DATA;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    P_DATA, P_ESC: begin
                        r_acc <= shift_in(r_acc, r_cnt == '0, rx_byte);
                        r_nz  <= nz_prev || (rx_byte != 8'h00);
                        if (!blk_last) begin
                            r_cnt <= r_cnt + 1'b1;
                        end else begin
                            r_cnt <= '0;
                            if (r_sess == P_DATA) begin
                                if (blk_zero) r_sess <= P_ESC;
                                else          r_pend <= 1'b1;
                            end else begin
                                unique case (1'b1)
                                    blk_zero: begin
                                        r_pend <= 1'b1;
                                        r_sess <= P_DATA;
                                    end
                                    blk_one: r_sess <= P_END;
                                    default: r_sess <= P_DATA;
                                endcase
                            end
                        end
                    end
                    default: ;
                endcase
            end

            if (r_sess == P_END && !r_opbusy && !r_pend && fifo_empty) begin
                r_n    <= '0;
                r_e    <= '0;
                r_acc  <= '0;
                r_nz   <= 1'b0;
                r_cnt  <= '0;
                r_sess <= P_KEY;
            end
        end
    end

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            r_bus         <= B_POLL;
            avm_address   <= 5'(STATUS_ADDR);
            avm_read      <= 1'b1;
            avm_write     <= 1'b0;
            avm_writedata <= '0;
            rx_stb        <= 1'b0;
            rx_byte       <= '0;
        end else begin
            rx_stb <= 1'b0;
            unique case (r_bus)
                B_POLL: begin
                    if (!avm_waitrequest) begin
                        if (avm_readdata[TX_OK_BIT] && !fifo_empty) begin
                            r_bus         <= B_TX;
                            avm_address   <= 5'(TX_ADDR);
                            avm_read      <= 1'b0;
                            avm_write     <= 1'b1;
                            avm_writedata <= {24'h0, fifo_head};
                        end else if (avm_readdata[RX_OK_BIT] &&
                                     !rx_stall) begin
                            r_bus       <= B_RX;
                            avm_address <= 5'(RX_ADDR);
                        end
                    end
                end
                B_RX: begin
                    if (!avm_waitrequest) begin
                        rx_byte     <= avm_readdata[7:0];
                        rx_stb      <= 1'b1;
                        r_bus       <= B_POLL;
                        avm_address <= 5'(STATUS_ADDR);
                    end
                end
                B_TX: begin
                    if (!avm_waitrequest) begin
                        r_bus         <= B_POLL;
                        avm_address   <= 5'(STATUS_ADDR);
                        avm_read      <= 1'b1;
                        avm_write     <= 1'b0;
                        avm_writedata <= '0;
                    end
                end
                default: r_bus <= B_POLL;
            endcase
        end
    end

endmodule
